// File: rtl/usb_packet_tx_if.sv
// usb_packet_tx_if
//  Bundles the request/handshake side and the line side of the full-speed
//  USB token/handshake transmitter so link control and the transmitter share
//  one connection.
//  master : link-control view (drives request fields, observes status/line)
//  slave  : transmitter view (consumes request fields, drives status/line)
//  Signals:
//   d_oe          line direction from link control, 1 = TX allowed
//   tx_req        transmit request
//   tx_pid        PID to send
//   tx_addr       token address
//   tx_endp       token endpoint
//   tx_busy       transmitter busy
//   tx_con_pid    PID of the packet most recently accepted
//   tx_con_pid_en one-clock pulse when a packet is accepted
//   tx_lp_eop_en  one-clock pulse when the packet's final J bit completes
//   tx_oe         transceiver drive enable
//   dp, dm        line levels
//   tx_err        rejected-PID pulse (only with USB_TX_PID_CHECK_EN)
interface usb_packet_tx_if;
    logic       d_oe;
    logic       tx_req;
    logic [3:0] tx_pid;
    logic [6:0] tx_addr;
    logic [3:0] tx_endp;
    logic       tx_busy;
    logic [3:0] tx_con_pid;
    logic       tx_con_pid_en;
    logic       tx_lp_eop_en;
    logic       tx_oe;
    logic       dp;
    logic       dm;
    logic       tx_err;

    modport master (
        output d_oe, tx_req, tx_pid, tx_addr, tx_endp,
        input  tx_busy, tx_con_pid, tx_con_pid_en, tx_lp_eop_en,
        input  tx_oe, dp, dm, tx_err
    );

    modport slave (
        input  d_oe, tx_req, tx_pid, tx_addr, tx_endp,
        output tx_busy, tx_con_pid, tx_con_pid_en, tx_lp_eop_en,
        output tx_oe, dp, dm, tx_err
    );
endinterface

// File: rtl/usb_packet_tx.sv
// usb_packet_tx
//  Full-speed USB token/handshake packet transmitter. Serialises SYNC, PID and,
//  for tokens, ADDR/ENDP/CRC5; bit-stuffs, NRZI-encodes onto dp/dm and finishes
//  with SE0,SE0,J. Pulses tx_con_pid_en on accept and tx_lp_eop_en when the
//  final J bit time completes.
//  Ports:
//   clk  in  single rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of usb_packet_tx_if (request fields in, status/line out)
//  Parameter:
//   CLK_PER_BIT  clocks per bit time (>=2)
//  Build option:
//   USB_TX_PID_CHECK_EN  when defined, requests carrying a PID that is neither
//   a token nor a handshake are dropped and tx_err pulses for one clock.
module usb_packet_tx #(
    parameter int CLK_PER_BIT = 4
) (
    input logic            clk,
    input logic            rst,
    usb_packet_tx_if.slave bus
);

    localparam int BW = $clog2(CLK_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_PID  = 3'd2;
    localparam logic [2:0] S_ADDR = 3'd3;
    localparam logic [2:0] S_ENDP = 3'd4;
    localparam logic [2:0] S_CRC  = 3'd5;
    localparam logic [2:0] S_EOP  = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    ones_q, ones_d;
    logic [4:0]    crc_q, crc_d;
    logic [3:0]    pid_q, pid_d;
    logic [6:0]    addr_q, addr_d;
    logic [3:0]    endp_q, endp_d;
    logic          busy_q, busy_d;
    logic          oe_q, oe_d;
    logic          pid_en_q, pid_en_d;
    logic          eop_en_q, eop_en_d;
    logic          j_q, j_d;
    logic          se0_q, se0_d;

    logic          req_ok;
    logic          accept;
    logic          tick;
    logic          data_bit;
    logic [2:0]    field_last;
    logic [2:0]    field_next;
    logic          crc_fb;
    logic [4:0]    crc_next;

    // The request can only land in IDLE, and not in the tx_lp_eop_en cycle,
    // so back-to-back packets are separated by at least one idle clock.
    assign req_ok = (state_q == S_IDLE) && !eop_en_q && bus.d_oe && bus.tx_req;
    assign tick   = (baud_q == BAUD_LAST);

`ifdef USB_TX_PID_CHECK_EN
    logic pid_valid;
    logic err_q;

    assign pid_valid = (bus.tx_pid[1:0] == 2'b01) || (bus.tx_pid == 4'b0010) ||
                       (bus.tx_pid == 4'b1010) || (bus.tx_pid == 4'b1110);
    assign accept    = req_ok && pid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= req_ok && !pid_valid;
        end
    end

    assign bus.tx_err = err_q;
`else
    assign accept     = req_ok;
    assign bus.tx_err = 1'b0;
`endif

    // Current data bit of the active field plus the field's last index and
    // successor. Handshake PIDs (anything not ending in 01) skip to EOP.
    always_comb begin
        data_bit   = 1'b0;
        field_last = 3'd7;
        field_next = S_EOP;
        case (state_q)
            S_SYNC: begin
                data_bit   = (bit_cnt_q == 3'd7);
                field_next = S_PID;
            end
            S_PID: begin
                data_bit   = bit_cnt_q[2] ? ~pid_q[bit_cnt_q[1:0]] : pid_q[bit_cnt_q[1:0]];
                field_next = (pid_q[1:0] == 2'b01) ? S_ADDR : S_EOP;
            end
            S_ADDR: begin
                data_bit   = addr_q[bit_cnt_q];
                field_last = 3'd6;
                field_next = S_ENDP;
            end
            S_ENDP: begin
                data_bit   = endp_q[bit_cnt_q[1:0]];
                field_last = 3'd3;
                field_next = S_CRC;
            end
            S_CRC: begin
                data_bit   = ~crc_q[3'd4 - bit_cnt_q];
                field_last = 3'd4;
                field_next = S_EOP;
            end
            default: begin
                data_bit   = 1'b0;
                field_last = 3'd7;
                field_next = S_EOP;
            end
        endcase
    end

    // CRC5 shift register, x^5+x^2+1, fed with ADDR/ENDP bits in wire order.
    assign crc_fb   = crc_q[4] ^ data_bit;
    assign crc_next = {crc_q[3:0], 1'b0} ^ (crc_fb ? 5'b00101 : 5'b00000);

    // Next-state logic. One bit is launched onto the line at every baud wrap;
    // the state then names the bit to launch at the following wrap. A stuffed
    // zero pre-empts the field bit whenever six ones have just gone out, which
    // also covers a stuff due right after the last CRC bit (checked while the
    // FSM already sits at the start of EOP).
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        crc_d     = crc_q;
        pid_d     = pid_q;
        addr_d    = addr_q;
        endp_d    = endp_q;
        busy_d    = busy_q;
        oe_d      = oe_q;
        pid_en_d  = 1'b0;
        eop_en_d  = 1'b0;
        j_d       = j_q;
        se0_d     = se0_q;

        if (state_q == S_IDLE) begin
            if (eop_en_q) begin
                busy_d = 1'b0;
                oe_d   = 1'b0;
            end
            if (accept) begin
                pid_d     = bus.tx_pid;
                addr_d    = bus.tx_addr;
                endp_d    = bus.tx_endp;
                pid_en_d  = 1'b1;
                busy_d    = 1'b1;
                oe_d      = 1'b1;
                state_d   = S_SYNC;
                bit_cnt_d = 3'd0;
                ones_d    = 3'd0;
                crc_d     = 5'b11111;
                baud_d    = BAUD_LAST;
            end
        end else begin
            baud_d = tick ? '0 : baud_q + BW'(1);
            if (tick) begin
                if (ones_q == 3'd6) begin
                    j_d    = ~j_q;
                    ones_d = 3'd0;
                end else if (state_q == S_EOP) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    case (bit_cnt_q)
                        3'd0, 3'd1: se0_d = 1'b1;
                        3'd2: begin
                            se0_d = 1'b0;
                            j_d   = 1'b1;
                        end
                        default: begin
                            state_d   = S_IDLE;
                            eop_en_d  = 1'b1;
                            bit_cnt_d = 3'd0;
                        end
                    endcase
                end else begin
                    j_d    = data_bit ? j_q : ~j_q;
                    ones_d = data_bit ? ones_q + 3'd1 : 3'd0;
                    if (state_q == S_ADDR || state_q == S_ENDP) begin
                        crc_d = crc_next;
                    end
                    if (bit_cnt_q == field_last) begin
                        bit_cnt_d = 3'd0;
                        state_d   = field_next;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
        end
    end

    // State registers; reset leaves the line idling at J with the driver off.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= 3'd0;
            ones_q    <= 3'd0;
            crc_q     <= 5'b11111;
            pid_q     <= 4'd0;
            addr_q    <= 7'd0;
            endp_q    <= 4'd0;
            busy_q    <= 1'b0;
            oe_q      <= 1'b0;
            pid_en_q  <= 1'b0;
            eop_en_q  <= 1'b0;
            j_q       <= 1'b1;
            se0_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            crc_q     <= crc_d;
            pid_q     <= pid_d;
            addr_q    <= addr_d;
            endp_q    <= endp_d;
            busy_q    <= busy_d;
            oe_q      <= oe_d;
            pid_en_q  <= pid_en_d;
            eop_en_q  <= eop_en_d;
            j_q       <= j_d;
            se0_q     <= se0_d;
        end
    end

    assign bus.tx_busy       = busy_q;
    assign bus.tx_con_pid    = pid_q;
    assign bus.tx_con_pid_en = pid_en_q;
    assign bus.tx_lp_eop_en  = eop_en_q;
    assign bus.tx_oe         = oe_q;
    assign bus.dp            = se0_q ? 1'b0 : j_q;
    assign bus.dm            = se0_q ? 1'b0 : ~j_q;

endmodule

// File: tb/tb_usb_packet_tx.sv
// tb_usb_packet_tx
//  Drives usb_packet_tx through reset, directed packets and random packets,
//  and compares every bit time on dp/dm plus the handshake pulses against a
//  packet-level model: field list -> CRC5 by polynomial division -> stuffing
//  -> NRZI -> EOP symbols.
module tb_usb_packet_tx;

    localparam int CPB = 4;
    localparam logic [1:0] SYM_J = 2'b10;

    logic clk = 1'b0;
    logic rst;

    usb_packet_tx_if bus();

    usb_packet_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         checkCount = 0;
    int         passCount  = 0;
    logic [1:0] expSym[$];
    logic [3:0] lastPid;

    // Single comparison point: counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        else
            passCount++;
    endtask

    // Drives every request-side input at once.
    task automatic applyStimulus(input logic req, input logic doe, input logic [3:0] pid,
                                 input logic [6:0] addr, input logic [3:0] endp);
        bus.tx_req  = req;
        bus.d_oe    = doe;
        bus.tx_pid  = pid;
        bus.tx_addr = addr;
        bus.tx_endp = endp;
    endtask

    function automatic logic isToken(input logic [3:0] pid);
        return (pid == 4'b0001) || (pid == 4'b1001) || (pid == 4'b0101) || (pid == 4'b1101);
    endfunction

    function automatic logic isValid(input logic [3:0] pid);
        return isToken(pid) || (pid == 4'b0010) || (pid == 4'b1010) || (pid == 4'b1110);
    endfunction

    // Packet model: builds the expected dp/dm symbol for every bit time.
    task automatic buildExpected(input logic [3:0] pid, input logic [6:0] addr,
                                 input logic [3:0] endp);
        logic        raw[$];
        logic        stuffed[$];
        logic [10:0] msg;
        logic [15:0] v;
        logic        lvl;
        int          ones;
        raw = {};
        stuffed = {};
        for (int i = 0; i < 8; i++) raw.push_back(i == 7);
        for (int i = 0; i < 4; i++) raw.push_back(pid[i]);
        for (int i = 0; i < 4; i++) raw.push_back(~pid[i]);
        if (isToken(pid)) begin
            for (int i = 0; i < 7; i++) begin
                raw.push_back(addr[i]);
                msg[10-i] = addr[i];
            end
            for (int i = 0; i < 4; i++) begin
                raw.push_back(endp[i]);
                msg[3-i] = endp[i];
            end
            // All-ones preset == complementing the first five message bits.
            v = {msg ^ 11'b11111_000000, 5'b00000};
            for (int b = 15; b >= 5; b--)
                if (v[b]) v = v ^ (16'b100101 << (b - 5));
            for (int i = 0; i < 5; i++) raw.push_back(~v[4-i]);
        end
        ones = 0;
        foreach (raw[i]) begin
            stuffed.push_back(raw[i]);
            ones = raw[i] ? ones + 1 : 0;
            if (ones == 6) begin
                stuffed.push_back(1'b0);
                ones = 0;
            end
        end
        expSym = {};
        lvl = 1'b1;
        foreach (stuffed[i]) begin
            if (!stuffed[i]) lvl = ~lvl;
            expSym.push_back(lvl ? 2'b10 : 2'b01);
        end
        expSym.push_back(2'b00);
        expSym.push_back(2'b00);
        expSym.push_back(SYM_J);
    endtask

    // Requests one packet and follows it to the end. expBits, when non-zero,
    // fixes the packet length in bit times independently of the model.
    task automatic sendPacket(input logic [3:0] pid, input logic [6:0] addr,
                              input logic [3:0] endp, input int expBits);
        int nb, tEnd, cyc, target;
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, pid, addr, endp);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, pid, addr, endp);
`ifdef USB_TX_PID_CHECK_EN
        if (!isValid(pid)) begin
            checkOutput("rej_err", 32'(bus.tx_err), 1);
            checkOutput("rej_pid_en", 32'(bus.tx_con_pid_en), 0);
            checkOutput("rej_busy", 32'(bus.tx_busy), 0);
            checkOutput("rej_con_pid", 32'(bus.tx_con_pid), 32'(lastPid));
            checkOutput("rej_line", 32'({bus.dp, bus.dm}), 32'(SYM_J));
            @(negedge clk);
            checkOutput("rej_err_1clk", 32'(bus.tx_err), 0);
            checkOutput("rej_idle", 32'(bus.tx_busy), 0);
            return;
        end
`endif
        checkOutput("acc_pid_en", 32'(bus.tx_con_pid_en), 1);
        checkOutput("acc_con_pid", 32'(bus.tx_con_pid), 32'(pid));
        checkOutput("acc_busy", 32'(bus.tx_busy), 1);
        checkOutput("acc_oe", 32'(bus.tx_oe), 1);
        checkOutput("acc_err", 32'(bus.tx_err), 0);
        checkOutput("acc_line", 32'({bus.dp, bus.dm}), 32'(SYM_J));
        buildExpected(pid, addr, endp);
        nb   = expSym.size();
        tEnd = (expBits != 0) ? CPB * expBits + 1 : CPB * nb + 1;
        cyc  = 0;
        for (int k = 0; k < nb; k++) begin
            target = 1 + CPB * k + CPB / 2;
            repeat (target - cyc) @(negedge clk);
            cyc = target;
            checkOutput($sformatf("line[%0d]", k), 32'({bus.dp, bus.dm}), 32'(expSym[k]));
            checkOutput("mid_busy", 32'({bus.tx_busy, bus.tx_oe, bus.tx_con_pid_en}), 32'b110);
            // Requests and d_oe changes mid-packet must be ignored.
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          4'($urandom), 7'($urandom), 4'($urandom));
        end
        applyStimulus(1'b0, 1'b1, pid, addr, endp);
        repeat (tEnd - 1 - cyc) @(negedge clk);
        checkOutput("eop_early", 32'(bus.tx_lp_eop_en), 0);
        @(negedge clk);
        checkOutput("eop_pulse", 32'(bus.tx_lp_eop_en), 1);
        checkOutput("eop_busy", 32'(bus.tx_busy), 1);
        @(negedge clk);
        checkOutput("end_state", 32'({bus.tx_lp_eop_en, bus.tx_busy, bus.tx_oe}), 0);
        checkOutput("end_line", 32'({bus.dp, bus.dm}), 32'(SYM_J));
        @(negedge clk);
        checkOutput("no_queued", 32'({bus.tx_con_pid_en, bus.tx_busy}), 0);
        lastPid = pid;
    endtask

    // Reset partway through a packet: immediate return to idle, no EOP pulse.
    task automatic resetMidPacket();
        int seen;
        seen = 0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 4'b1001, 7'h33, 4'h2);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 4'b1001, 7'h33, 4'h2);
        checkOutput("rmp_started", 32'(bus.tx_busy), 1);
        repeat ($urandom_range(5, 120)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rmp_flags", 32'({bus.tx_busy, bus.tx_oe, bus.tx_con_pid_en,
                                      bus.tx_lp_eop_en, bus.tx_err}), 0);
        checkOutput("rmp_line", 32'({bus.dp, bus.dm}), 32'(SYM_J));
        checkOutput("rmp_con_pid", 32'(bus.tx_con_pid), 0);
        rst = 1'b0;
        lastPid = 4'd0;
        repeat (200) begin
            @(negedge clk);
            if (bus.tx_lp_eop_en || bus.tx_busy) seen++;
        end
        checkOutput("rmp_quiet", 32'(seen), 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        lastPid = 4'd0;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'b0010, 7'h0, 4'h0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_line", 32'({bus.dp, bus.dm}), 32'(SYM_J));
            checkOutput("rst_flags", 32'({bus.tx_busy, bus.tx_oe, bus.tx_con_pid_en,
                                          bus.tx_lp_eop_en, bus.tx_err}), 0);
            checkOutput("rst_con_pid", 32'(bus.tx_con_pid), 0);
        end
        applyStimulus(1'b0, 1'b1, 4'b0010, 7'h0, 4'h0);
        rst = 1'b0;
        @(negedge clk);

        sendPacket(4'b0010, 7'h00, 4'h0, 19);
        sendPacket(4'b0001, 7'h15, 4'hE, 35);
        sendPacket(4'b1001, 7'h7F, 4'hF, 0);
        sendPacket(4'b0011, 7'h00, 4'h0, 19);

        // Request while direction is not ours: never accepted.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'b1010, 7'h0, 4'h0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("doe_low", 32'({bus.tx_con_pid_en, bus.tx_busy, bus.tx_oe}), 0);
        end
        applyStimulus(1'b0, 1'b1, 4'b1010, 7'h0, 4'h0);

        for (int n = 0; n < 20; n++)
            sendPacket(4'($urandom), 7'($urandom), 4'($urandom), 0);

        resetMidPacket();
        sendPacket(4'b1110, 7'h00, 4'h0, 19);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
